// File: rtl/adder_bist_pkg.sv
// Shared types and vector-field layout for the ripple-adder self-test sequencer.
// The expected-result helper is plain behavioural addition, independent of the adder under test.
package adder_bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int VEC_W   = 9;
    localparam int NUM_VEC = 512;
    localparam int OP_W    = 4;
    localparam int ERR_W   = 10;

    // v = {cin, a[3:0], b[3:0]}
    localparam int CIN_POS = 8;
    localparam int A_LSB   = 4;
    localparam int B_LSB   = 0;

    localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VEC - 1);

    function automatic logic [OP_W:0] expected_sum(input logic [VEC_W-1:0] vec);
        logic [OP_W-1:0] a, b;
        logic            c;
        a = vec[A_LSB +: OP_W];
        b = vec[B_LSB +: OP_W];
        c = vec[CIN_POS];
        return {1'b0, a} + {1'b0, b} + {{OP_W{1'b0}}, c};
    endfunction

endpackage

// File: rtl/adder_bist.sv
// Exhaustive self-test of a 4-bit adder: sweeps all 512 {cin,a,b} vectors, holds each
// for SETTLE_CYCLES, samples the result once and tallies mismatches and the first failure.
module adder_bist
    import adder_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2   // legal range 1..15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [OP_W-1:0]  a_out,
    output logic [OP_W-1:0]  b_out,
    output logic             cin_out,
    input  logic [OP_W-1:0]  sum_in,
    input  logic             cout_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [VEC_W-1:0] first_fail
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t             state, state_nx;
    logic [VEC_W-1:0]   v, v_nx;
    logic [3:0]         cnt, cnt_nx;
    logic [ERR_W-1:0]   err_nx;
    logic [VEC_W-1:0]   ff_nx;
    logic               pass_nx;
    logic [OP_W:0]      exp_res;
    logic               mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            v          <= '0;
            cnt        <= '0;
            err_count  <= '0;
            first_fail <= '0;
            pass       <= 1'b0;
        end else begin
            state      <= state_nx;
            v          <= v_nx;
            cnt        <= cnt_nx;
            err_count  <= err_nx;
            first_fail <= ff_nx;
            pass       <= pass_nx;
        end
    end

    always_comb begin
        state_nx = state;
        v_nx     = v;
        cnt_nx   = cnt;
        err_nx   = err_count;
        ff_nx    = first_fail;
        pass_nx  = pass;
        exp_res  = expected_sum(v);
        mismatch = ({cout_in, sum_in} != exp_res);

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx = SETTLE;
                    v_nx     = '0;
                    cnt_nx   = '0;
                    err_nx   = '0;
                    ff_nx    = '0;
                    pass_nx  = 1'b0;
                end
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) state_nx = CHECK;
                else                    cnt_nx   = cnt + 4'd1;
            end
            CHECK: begin
                if (mismatch) begin
                    err_nx = err_count + 10'd1;
                    if (err_count == '0) ff_nx = v;
                end
                if (v == VEC_LAST) begin
                    state_nx = DONE;
                    // pass must land together with done, so it uses the updated count
                    pass_nx  = (err_nx == '0);
                end else begin
                    state_nx = SETTLE;
                    v_nx     = v + 9'd1;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operands come straight from the vector register, so they only move on CHECK->SETTLE.
    assign cin_out = v[CIN_POS];
    assign a_out   = v[A_LSB +: OP_W];
    assign b_out   = v[B_LSB +: OP_W];

    assign busy = (state == SETTLE) || (state == CHECK);
    assign done = (state == DONE);

endmodule

// File: tb/tb_adder_bist.sv
// Directed bench for adder_bist: good adder, stuck-at faults, mid-sweep reset,
// start held high across a run, and a SETTLE_CYCLES=1 instance.
module tb_adder_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, start2;
    logic [3:0] a, b, s_sum;
    logic       cin, s_cout;
    logic       busy, done, pass;
    logic [9:0] errc;
    logic [8:0] ff;
    int         fault;

    logic [3:0] a2, b2, s_sum2;
    logic       cin2, s_cout2;
    logic       busy2, done2, pass2;
    logic [9:0] errc2;
    logic [8:0] ff2;

    int n_cmp = 0;
    int n_bad = 0;
    int ecur  = 0;

    // Adder model with optional faults: 1 = cout stuck-at-0, 2 = sum[0] stuck-at-1
    always_comb begin
        {s_cout, s_sum} = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        if (fault == 1) s_cout   = 1'b0;
        if (fault == 2) s_sum[0] = 1'b1;
    end

    always_comb {s_cout2, s_sum2} = {1'b0, a2} + {1'b0, b2} + {4'b0, cin2};

    adder_bist #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_out(a), .b_out(b), .cin_out(cin),
        .sum_in(s_sum), .cout_in(s_cout),
        .busy(busy), .done(done), .pass(pass),
        .err_count(errc), .first_fail(ff)
    );

    adder_bist #(.SETTLE_CYCLES(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .a_out(a2), .b_out(b2), .cin_out(cin2),
        .sum_in(s_sum2), .cout_in(s_cout2),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_count(errc2), .first_fail(ff2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; the following posedge becomes edge 0.
    task automatic begin_run(input logic hold);
        start = 1'b1;
        @(posedge clk);
        ecur = 0;
        @(negedge clk);
        start = hold;
    endtask

    // Advance to just after edge n, then sample at the following negedge.
    task automatic go(input int n);
        repeat (n - ecur) @(posedge clk);
        ecur = n;
        @(negedge clk);
    endtask

    task automatic go_busy(input int n, input string tag);
        logic ok;
        ok = 1'b1;
        while (ecur < n) begin
            @(posedge clk);
            ecur++;
            @(negedge clk);
            if (!busy) ok = 1'b0;
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        fault  = 0;
        start  = 1'b0;
        start2 = 1'b0;
        rst_n  = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_err",  32'(errc), 32'd0);
        chk("rst_ff",   32'(ff),   32'd0);
        chk("rst_vec",  32'({cin, a, b}), 32'd0);
        chk("rst_busy2", 32'(busy2), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Good adder, default settle
        begin_run(1'b0);
        chk("good_busy_e0", 32'(busy), 32'd1);
        chk("good_vec_e0",  32'({cin, a, b}), 32'd0);
        go(2);
        chk("good_vec_e2",  32'({cin, a, b}), 32'd0);
        go(3);
        chk("good_vec_e3",  32'({cin, a, b}), 32'd1);
        go_busy(1535, "good_busy_sweep");
        chk("good_done_e1535", 32'(done), 32'd0);
        go(1536);
        chk("good_done", 32'(done), 32'd1);
        chk("good_pass", 32'(pass), 32'd1);
        chk("good_busy", 32'(busy), 32'd0);
        chk("good_err",  32'(errc), 32'd0);
        chk("good_ff",   32'(ff),   32'd0);
        go(1540);
        chk("good_done_held", 32'(done), 32'd1);

        // Cout stuck-at-0 with start held high for the whole run
        fault = 1;
        begin_run(1'b1);
        go(95);
        chk("cout_err_e95", 32'(errc), 32'd0);
        go(96);
        chk("cout_err_e96", 32'(errc), 32'd1);
        chk("cout_ff_e96",  32'(ff),   32'h01F);
        go_busy(1535, "cout_busy_sweep");
        go(1536);
        chk("cout_done", 32'(done), 32'd1);
        chk("cout_err",  32'(errc), 32'd256);
        chk("cout_ff",   32'(ff),   32'h01F);
        chk("cout_pass", 32'(pass), 32'd0);
        go(1537);
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_err",  32'(errc), 32'd0);
        chk("restart_vec",  32'({cin, a, b}), 32'd0);

        // Mid-sweep asynchronous reset at edge 700 of the restarted run
        ecur  = 0;
        start = 1'b0;
        repeat (700 - ecur) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_err",  32'(errc), 32'd0);
        chk("mrst_ff",   32'(ff),   32'd0);
        chk("mrst_vec",  32'({cin, a, b}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        fault = 0;
        @(negedge clk);
        chk("mrst_idle", 32'(busy), 32'd0);
        begin_run(1'b0);
        go(1535);
        chk("mrst_done_e1535", 32'(done), 32'd0);
        go(1536);
        chk("mrst_done", 32'(done), 32'd1);
        chk("mrst_pass", 32'(pass), 32'd1);

        // Sum[0] stuck-at-1
        fault = 2;
        begin_run(1'b0);
        go(1536);
        chk("s0_done", 32'(done), 32'd1);
        chk("s0_err",  32'(errc), 32'd256);
        chk("s0_ff",   32'(ff),   32'd0);
        chk("s0_pass", 32'(pass), 32'd0);
        fault = 0;

        // SETTLE_CYCLES = 1 instance
        start2 = 1'b1;
        @(posedge clk);
        ecur = 0;
        @(negedge clk);
        start2 = 1'b0;
        chk("s1_vec_e0", 32'({cin2, a2, b2}), 32'd0);
        go(1);
        chk("s1_vec_e1", 32'({cin2, a2, b2}), 32'd0);
        go(2);
        chk("s1_vec_e2", 32'({cin2, a2, b2}), 32'd1);
        go(4);
        chk("s1_vec_e4", 32'({cin2, a2, b2}), 32'd2);
        go(1023);
        chk("s1_done_e1023", 32'(done2), 32'd0);
        go(1024);
        chk("s1_done", 32'(done2), 32'd1);
        chk("s1_pass", 32'(pass2), 32'd1);
        chk("s1_err",  32'(errc2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
